vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Owns the single-port framebuffer RAM behind the VGA timing generator, and shares it between display scan-out and a write requester/fill engine.
- Takes the generator's row_i/col_i/sync/blank, fetches 4x-upscaled pixels from a 160x120x8 framebuffer, and emits pixel data plus delayed syncs aligned to it.
- Non-display RAM cycles go to a built-in clear/fill sequencer first, then to an external valid/ready write port.

Parameters:
H_VIS, 640, visible columns
V_VIS, 480, visible rows
SCALE_LOG2, 2, upscale shift (4x4 screen pixels per framebuffer pixel)
FB_W, 160, framebuffer width (H_VIS>>SCALE_LOG2)
FB_H, 120, framebuffer height (V_VIS>>SCALE_LOG2)
ADDR_W, 15, framebuffer address width
PIX_W, 8, pixel width

Ports:
clk  in  1  system/pixel clock
reset  in  1  synchronous, active-high reset
row_i  in  10  current row from timing generator
col_i  in  10  current column from timing generator
sync_h_i  in  1  hsync from generator (active-low)
sync_v_i  in  1  vsync from generator (active-low)
blank_n_i  in  1  visible-area flag from generator
ram_addr  out  ADDR_W  RAM address (combinational)
ram_we  out  1  RAM write enable (combinational)
ram_wdata  out  PIX_W  RAM write data (combinational)
ram_rdata  in  PIX_W  RAM read data, valid 1 cycle after address
wr_valid  in  1  external write request
wr_ready  out  1  external write accepted this cycle (combinational)
wr_addr  in  ADDR_W  external write address
wr_data  in  PIX_W  external write data
fill_start  in  1  start full-framebuffer fill
fill_color  in  PIX_W  fill value, sampled with fill_start
fill_busy  out  1  fill in progress
pixel_o  out  PIX_W  pixel for the VGA DAC
sync_h_o  out  1  sync_h_i delayed 2 cycles
sync_v_o  out  1  sync_v_i delayed 2 cycles
blank_n_o  out  1  blank_n_i delayed 2 cycles
vblank_o  out  1  1-cycle pulse when row_i==V_VIS and col_i==0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset values:
  - pixel_o=0, pixel register=0, blank_n_o=0.
  - sync_h_o=1, sync_v_o=1.
  - fill_busy=0, state IDLE, fill counter=0, vblank_o=0.
  - While reset=1: ram_we=0, wr_ready=0.
- Display slot: a cycle with blank_n_i=1 and col_i[1:0]==0.
  - ram_addr = (row_i>>2)*FB_W + (col_i>>2), ram_we=0.
  - Multiply is shift-add: (r<<7)+(r<<5); max address 19199.
- Pixel register loads ram_rdata in the cycle after a display slot and holds for 4 cycles.
- Output stage is registered, 2-cycle latency from the timing inputs:
  - sync_h_o, sync_v_o and blank_n_o are the inputs delayed by 2 registers.
  - pixel_o = (blank_n delayed 1) ? pixel register : 0, registered.
  - pixel_o for screen (r,c) appears exactly 2 cycles after row_i=r, col_i=c.
- Non-display cycles: the RAM goes to the fill engine if fill_busy, else to the external port.
- FSM states: IDLE and FILL.
  - IDLE -> FILL: on fill_start. Latch fill_color, counter=0.
  - In FILL: each non-display cycle writes fill_color to address counter, then counter++.
  - FILL -> IDLE: in the cycle after the write to FB_W*FB_H-1.
  - fill_start while in FILL is ignored.
- External port:
  - wr_ready=1 iff reset=0, state IDLE, and not a display slot.
  - A transfer completes when wr_valid&wr_ready.
  - ram_we=1 only if wr_addr < FB_W*FB_H. Out-of-range writes are accepted and dropped.
  - wr_ready does not depend on wr_valid.
- fill_start and wr_valid in the same IDLE cycle: the write is accepted that cycle; the fill starts next cycle.
- Idle RAM cycles (no fill, no valid): ram_addr=0, ram_we=0.
- Reset mid-fill: fill aborts at once; the next cycle is IDLE and fill_busy=0.
- Reset mid-frame: the output pipeline clears. Timing inputs are followed again from the first post-reset cycle.

Test Plan:
- Reset, then free-run one frame with a RAM model.
  - Expect sync_h_o/sync_v_o/blank_n_o to equal the inputs delayed exactly 2 cycles.
  - Expect pixel_o=0 whenever blank_n_o=0.
- Preload RAM[i]=i[7:0], drive row 5, cols 0..15.
  - Expect pixel_o = RAM[160] for 4 cycles, then RAM[161], RAM[162], RAM[163], each for 4 cycles, starting 2 cycles after col 0.
- Hold wr_valid=1 with wr_addr=100, data 0xAB during the visible area.
  - wr_ready=0 exactly on col[1:0]==0 cycles.
  - RAM[100]=0xAB after the handshake.
  - No display read is displaced.
- Pulse fill_start with color 0x3C during vblank.
  - fill_busy=1 for exactly 19200 cycles, as vblank has no display slots; wr_ready=0 throughout.
  - All RAM locations hold 0x3C.
- Assert reset after 500 fill writes.
  - fill_busy=0 next cycle; RAM[500..] unchanged.
  - A new fill_start restarts from address 0.
- Write to wr_addr=19200.
  - wr_ready=1 and ram_we=0; no RAM location changes.
- Same-cycle fill_start and wr_valid in IDLE.
  - The write lands, then the fill overwrites it.
- Check vblank_o.
  - Exactly one pulse per frame, at row 480 col 0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Owns the single-port 160x120x8 framebuffer RAM behind the VGA timing
//   generator. Display scan-out has absolute priority on one RAM cycle per
//   4 screen columns; every other cycle goes to the clear/fill sequencer
//   while it runs, otherwise to the external valid/ready write port.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   row_i, col_i                  current raster position from the generator
//   sync_h_i, sync_v_i, blank_n_i generator syncs (active-low) / visible flag
//   ram_addr, ram_we, ram_wdata   RAM command (combinational)
//   ram_rdata                     RAM read data, one cycle after ram_addr
//   wr_valid/wr_ready/wr_addr/wr_data  external write port
//   fill_start, fill_color        start a full-framebuffer fill
//   fill_busy                     fill in progress
//   pixel_o, sync_h_o, sync_v_o, blank_n_o  outputs, 2 cycles behind inputs
//   vblank_o                      1-cycle pulse, registered, in the cycle
//                                 after row_i==V_VIS && col_i==0
module vga_fb_arbiter #(
  parameter int H_VIS      = 640,
  parameter int V_VIS      = 480,
  parameter int SCALE_LOG2 = 2,
  parameter int FB_W       = H_VIS >> SCALE_LOG2,
  parameter int FB_H       = V_VIS >> SCALE_LOG2,
  parameter int ADDR_W     = 15,
  parameter int PIX_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        row_i,
  input  logic [9:0]        col_i,
  input  logic              sync_h_i,
  input  logic              sync_v_i,
  input  logic              blank_n_i,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              fill_start,
  input  logic [PIX_W-1:0]  fill_color,
  output logic              fill_busy,
  output logic [PIX_W-1:0]  pixel_o,
  output logic              sync_h_o,
  output logic              sync_v_o,
  output logic              blank_n_o,
  output logic              vblank_o
);

  localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_W * FB_H - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fill_cnt, fill_cnt_nxt;
  logic [PIX_W-1:0]  fill_col, fill_col_nxt;

  // One RAM read per framebuffer pixel: first screen column of each 4-wide group.
  logic              disp_slot;
  logic [ADDR_W-1:0] fb_row, fb_col, disp_addr;

  assign disp_slot = blank_n_i && (col_i[SCALE_LOG2-1:0] == '0);
  assign fb_row    = ADDR_W'(row_i >> SCALE_LOG2);
  assign fb_col    = ADDR_W'(col_i >> SCALE_LOG2);
  // row*160 as shift-add; tied to FB_W == 160.
  assign disp_addr = (fb_row << 7) + (fb_row << 5) + fb_col;

  assign fill_busy = (state == FILL);

  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    fill_col_nxt = fill_col;
    ram_addr     = '0;
    ram_we       = 1'b0;
    ram_wdata    = '0;
    wr_ready     = 1'b0;

    if (disp_slot) begin
      ram_addr = disp_addr;
    end else if (state == FILL) begin
      ram_addr     = fill_cnt;
      ram_we       = 1'b1;
      ram_wdata    = fill_col;
      fill_cnt_nxt = fill_cnt + 1'b1;
      if (fill_cnt == FB_LAST) state_nxt = IDLE;
    end else begin
      wr_ready = 1'b1;
      if (wr_valid) begin
        // Out-of-range writes complete the handshake but never reach the RAM.
        ram_addr  = wr_addr;
        ram_we    = (wr_addr < FB_SIZE);
        ram_wdata = wr_data;
      end
    end

    // A fill request in IDLE takes effect next cycle, so a same-cycle
    // external write still lands first.
    if (state == IDLE && fill_start) begin
      state_nxt    = FILL;
      fill_cnt_nxt = '0;
      fill_col_nxt = fill_color;
    end

    if (reset) begin
      ram_we   = 1'b0;
      wr_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fill_cnt <= '0;
      fill_col <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_cnt_nxt;
      fill_col <= fill_col_nxt;
    end
  end

  // Output pipeline. Stage 1 sees RAM data for the slot issued last cycle;
  // the pixel register is bypassed on that cycle so pixel_o lands exactly
  // two cycles after its raster position.
  logic             slot_d1;
  logic [1:0]       vld_pipe;  // blank_n delay line
  logic             sync_h_d1, sync_v_d1;
  logic [PIX_W-1:0] pix_reg, pix_nxt;

  assign pix_nxt   = slot_d1 ? ram_rdata : pix_reg;
  assign blank_n_o = vld_pipe[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_d1   <= 1'b0;
      vld_pipe  <= '0;
      sync_h_d1 <= 1'b1;
      sync_v_d1 <= 1'b1;
      sync_h_o  <= 1'b1;
      sync_v_o  <= 1'b1;
      pix_reg   <= '0;
      pixel_o   <= '0;
      vblank_o  <= 1'b0;
    end else begin
      slot_d1   <= disp_slot;
      vld_pipe  <= {vld_pipe[0], blank_n_i};
      sync_h_d1 <= sync_h_i;
      sync_v_d1 <= sync_v_i;
      sync_h_o  <= sync_h_d1;
      sync_v_o  <= sync_v_d1;
      pix_reg   <= pix_nxt;
      pixel_o   <= vld_pipe[0] ? pix_nxt : '0;
      vblank_o  <= (row_i == 10'(V_VIS)) && (col_i == 10'd0);
    end
  end

endmodule
